// File: rtl/clk_div_mon_pkg.sv
// Shared types, defaults and the period-acceptance rule for the divided-clock monitor.
package clk_div_mon_pkg;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned LOCK_N_DEF = 4;
  localparam int unsigned CMP_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    MEASURE,
    LOCKED,
    ERROR
  } mon_state_t;

  // A period is good when it matches the ratio exactly and the duty is as close to 50% as possible.
  function automatic logic is_good_period(input logic [CMP_W-1:0] per,
                                          input logic [CMP_W-1:0] hi,
                                          input logic [CMP_W-1:0] e);
    return (per == e) && ((hi == (e >> 1)) || (hi == ((e + CMP_W'(1)) >> 1)));
  endfunction

endpackage

// File: rtl/clk_period_meter.sv
// One monitored channel: edge detect, period/high-time counters and lock/error FSM.
module clk_period_meter
  import clk_div_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned LOCK_N = LOCK_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_clk,
  input  logic [CNT_W-1:0] exp_div,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] meas_period
);

  localparam int unsigned CW = CNT_W + 1;
  localparam int unsigned LW = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] MEAS_MAX = CW'((1 << CNT_W) - 1);

  mon_state_t       state_q, state_d;
  logic             prev_q;
  logic [CNT_W-1:0] e_q, e_d;
  logic [CW-1:0]    per_q, per_d, hi_q, hi_d, wait_q, wait_d;
  logic [LW-1:0]    good_q, good_d, bad_q, bad_d;
  logic [CNT_W-1:0] meas_d;
  logic             rise;
  logic             period_ok;

  // Next-state and datapath; en low overrides everything at the end.
  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    per_d     = per_q;
    hi_d      = hi_q;
    wait_d    = wait_q;
    good_d    = good_q;
    bad_d     = bad_q;
    meas_d    = meas_period;
    rise      = div_clk & ~prev_q;
    period_ok = is_good_period(CMP_W'(per_q), CMP_W'(hi_q), CMP_W'(e_q));

    if (rise) begin
      per_d = CW'(1);
      hi_d  = CW'(1);
    end else begin
      per_d = (per_q == '1) ? per_q : per_q + CW'(1);
      hi_d  = (hi_q == '1) ? hi_q : hi_q + CW'(div_clk);
    end

    case (state_q)
      IDLE: begin
        if (exp_div >= CNT_W'(2)) begin
          state_d = SYNC;
          e_d     = exp_div;
          wait_d  = '0;
        end
      end
      SYNC: begin
        if (rise) begin
          state_d = MEASURE;
          good_d  = '0;
          bad_d   = '0;
        end else if (wait_q == ((CW'(e_q) << 1) - CW'(1))) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      MEASURE, LOCKED: begin
        if (rise) begin
          meas_d = (per_q > MEAS_MAX) ? MEAS_MAX[CNT_W-1:0] : per_q[CNT_W-1:0];
          if (period_ok) begin
            if (state_q == MEASURE) begin
              bad_d = '0;
              if (good_q == LW'(LOCK_N - 1)) state_d = LOCKED;
              else good_d = good_q + LW'(1);
            end
          end else if (state_q == LOCKED) begin
            state_d = ERROR;
          end else begin
            good_d = '0;
            if (bad_q == LW'(LOCK_N - 1)) state_d = ERROR;
            else bad_d = bad_q + LW'(1);
          end
        end else if (per_q == (CW'(e_q) + CW'(1))) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      e_d     = '0;
      per_d   = '0;
      hi_d    = '0;
      wait_d  = '0;
      good_d  = '0;
      bad_d   = '0;
      meas_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= 1'b0;
      e_q         <= '0;
      per_q       <= '0;
      hi_q        <= '0;
      wait_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      meas_period <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= div_clk;
      e_q         <= e_d;
      per_q       <= per_d;
      hi_q        <= hi_d;
      wait_q      <= wait_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      locked      <= (state_d == LOCKED);
      err         <= (state_d == ERROR);
      meas_period <= meas_d;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Receive-side checker for NCH divided clocks; one independent meter per channel.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int unsigned NCH    = 3,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned LOCK_N = LOCK_N_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       div_clk,
  input  logic [NCH*CNT_W-1:0] exp_div,
  output logic [NCH-1:0]       locked,
  output logic [NCH-1:0]       err,
  output logic [NCH*CNT_W-1:0] meas_period
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_period_meter #(
      .CNT_W  (CNT_W),
      .LOCK_N (LOCK_N)
    ) u_meter (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .div_clk     (div_clk[i]),
      .exp_div     (exp_div[i*CNT_W +: CNT_W]),
      .locked      (locked[i]),
      .err         (err[i]),
      .meas_period (meas_period[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized and directed bench for clk_div_monitor against a cycle-stamp reference model.
module tb_clk_div_monitor;

  localparam int unsigned NCH    = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LOCK_N = 4;

  localparam int S_IDLE = 0;
  localparam int S_SYNC = 1;
  localparam int S_MEAS = 2;
  localparam int S_LOCK = 3;
  localparam int S_ERR  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NCH-1:0]       div_clk;
  logic [NCH*CNT_W-1:0] exp_div;
  logic [NCH-1:0]       locked;
  logic [NCH-1:0]       err;
  logic [NCH*CNT_W-1:0] meas_period;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .NCH    (NCH),
    .CNT_W  (CNT_W),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div_clk     (div_clk),
    .exp_div     (exp_div),
    .locked      (locked),
    .err         (err),
    .meas_period (meas_period)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus waveform generators: mode 0 runs hi/lo, 1 stuck low, 2 stuck high.
  int g_hi[NCH], g_lo[NCH], g_ph[NCH], g_mode[NCH];
  int e_in[NCH];

  // Reference model: times are absolute cycle stamps rather than counters.
  int m_mode[NCH], m_e[NCH], m_last[NCH], m_hi[NCH], m_start[NCH];
  int m_good[NCH], m_bad[NCH], m_meas[NCH];
  bit m_prev[NCH];
  int cyc = 0;

  task automatic set_wave(input int i, input int hi, input int lo);
    g_mode[i] = 0;
    g_hi[i]   = hi;
    g_lo[i]   = lo;
    g_ph[i]   = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit d;
      bit r;
      int ecap;
      d    = div_clk[i];
      r    = d && !m_prev[i];
      ecap = int'(exp_div[i*CNT_W +: CNT_W]);
      m_prev[i] = rst ? 1'b0 : d;
      if (rst || !en) begin
        m_mode[i] = S_IDLE;
        m_meas[i] = 0;
        continue;
      end
      case (m_mode[i])
        S_IDLE: if (ecap >= 2) begin
          m_e[i] = ecap; m_mode[i] = S_SYNC; m_start[i] = cyc;
        end
        S_SYNC: begin
          if (r) begin
            m_mode[i] = S_MEAS; m_last[i] = cyc; m_hi[i] = 1; m_good[i] = 0; m_bad[i] = 0;
          end else if (cyc - m_start[i] == 2 * m_e[i]) begin
            m_mode[i] = S_ERR;
          end
        end
        S_MEAS, S_LOCK: begin
          if (r) begin
            int p;
            bit ok;
            p  = cyc - m_last[i];
            ok = (p == m_e[i]) && (m_hi[i] == m_e[i] / 2 || m_hi[i] == (m_e[i] + 1) / 2);
            m_meas[i] = (p > 255) ? 255 : p;
            m_last[i] = cyc;
            m_hi[i]   = 1;
            if (m_mode[i] == S_LOCK) begin
              if (!ok) m_mode[i] = S_ERR;
            end else if (ok) begin
              m_good[i]++; m_bad[i] = 0;
              if (m_good[i] == LOCK_N) m_mode[i] = S_LOCK;
            end else begin
              m_bad[i]++; m_good[i] = 0;
              if (m_bad[i] == LOCK_N) m_mode[i] = S_ERR;
            end
          end else begin
            m_hi[i] += int'(d);
            if (cyc - m_last[i] == m_e[i] + 1) m_mode[i] = S_ERR;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare every output.
  task automatic tick();
    for (int i = 0; i < NCH; i++) begin
      div_clk[i] = (g_mode[i] == 1) ? 1'b0 : (g_mode[i] == 2) ? 1'b1 : (g_ph[i] < g_hi[i]);
      g_ph[i]    = (g_ph[i] + 1) % (g_hi[i] + g_lo[i]);
      exp_div[i*CNT_W +: CNT_W] = CNT_W'(e_in[i]);
    end
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    for (int i = 0; i < NCH; i++) begin
      check_eq($sformatf("ch%0d locked", i), 32'(locked[i]), 32'(m_mode[i] == S_LOCK));
      check_eq($sformatf("ch%0d err", i), 32'(err[i]), 32'(m_mode[i] == S_ERR));
      check_eq($sformatf("ch%0d meas", i), 32'(meas_period[i*CNT_W +: CNT_W]), 32'(m_meas[i]));
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_en_low();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  initial begin
    int e, k, hi, p, n, glitch_at, glitch_kind;
    rst = 1'b1;
    en  = 1'b0;
    div_clk = '0;
    exp_div = '0;
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = S_IDLE; m_prev[i] = 1'b0; m_meas[i] = 0;
    end

    // Reset state, then clk2/clk4/clk6 with matching ratios.
    set_wave(0, 1, 1); set_wave(1, 2, 2); set_wave(2, 3, 3);
    e_in[0] = 2; e_in[1] = 4; e_in[2] = 6;
    run(2);
    check_eq("reset locked", 32'(locked), 32'd0);
    check_eq("reset err", 32'(err), 32'd0);
    check_eq("reset meas", 32'(meas_period), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    run(50);
    check_eq("t1 locked", 32'(locked), 32'h7);
    check_eq("t1 err", 32'(err), 32'h0);
    check_eq("t1 meas", 32'(meas_period), 32'h060402);

    // Ratio 6 on a channel expecting 4.
    set_wave(0, 3, 3); e_in[0] = 4;
    set_wave(1, 2, 2); set_wave(2, 3, 3);
    e_in[1] = 4; e_in[2] = 6;
    pulse_en_low();
    run(60);
    check_eq("t2 err", 32'(err), 32'h1);
    check_eq("t2 locked", 32'(locked), 32'h6);

    // Locked channel whose clock stops.
    g_mode[1] = 1;
    run(10);
    check_eq("t3 err", 32'(err), 32'h3);
    check_eq("t3 locked", 32'(locked), 32'h4);

    // Odd ratio: 3/2 locks, 4/1 is a duty error.
    set_wave(0, 3, 2); e_in[0] = 5; set_wave(1, 2, 2);
    pulse_en_low();
    run(60);
    check_eq("t4 locked", 32'(locked), 32'h7);
    set_wave(0, 4, 1);
    pulse_en_low();
    run(40);
    check_eq("t4 err", 32'(err), 32'h1);

    // en and rst pulses clear a locked monitor, which then relocks.
    set_wave(0, 3, 2);
    pulse_en_low();
    run(60);
    en = 1'b0;
    tick();
    check_eq("t5 en locked", 32'(locked), 32'h0);
    check_eq("t5 en meas", 32'(meas_period), 32'h0);
    en = 1'b1;
    run(60);
    check_eq("t5 relock", 32'(locked), 32'h7);
    rst = 1'b1;
    tick();
    check_eq("t5 rst locked", 32'(locked), 32'h0);
    check_eq("t5 rst meas", 32'(meas_period), 32'h0);
    rst = 1'b0;
    run(60);
    check_eq("t5 rst relock", 32'(locked), 32'h7);

    // Ratios below 2 never start; ratio 255 locks at full scale.
    e_in[0] = 0; e_in[1] = 1; e_in[2] = 255;
    set_wave(2, 128, 127);
    pulse_en_low();
    run(1400);
    check_eq("t6 low ratios", 32'({locked[1:0], err[1:0]}), 32'h0);
    check_eq("t6 locked255", 32'(locked[2]), 32'd1);
    check_eq("t6 meas255", 32'(meas_period[2*CNT_W +: CNT_W]), 32'd255);

    // Random epochs: ratio, waveform and mid-run disturbances all drawn at random.
    for (int ep = 0; ep < 30; ep++) begin
      for (int i = 0; i < NCH; i++) begin
        e = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
        e_in[i] = e;
        k = int'($urandom_range(0, 9));
        if (e < 2) begin
          hi = int'($urandom_range(1, 4));
          set_wave(i, hi, int'($urandom_range(1, 4)));
        end else if (k <= 5) begin
          hi = ($urandom_range(0, 1) == 1) ? (e + 1) / 2 : e / 2;
          set_wave(i, hi, e - hi);
        end else if (k <= 7) begin
          p = ($urandom_range(0, 1) == 1) ? e + 1 : ((e > 2) ? e - 1 : 3);
          set_wave(i, p / 2, p - p / 2);
        end else if (k == 8) begin
          set_wave(i, 1, e - 1);
        end else begin
          set_wave(i, 1, 1);
          g_mode[i] = int'($urandom_range(1, 2));
        end
        g_ph[i] = int'($urandom_range(0, 31)) % (g_hi[i] + g_lo[i]);
      end
      pulse_en_low();
      n = int'($urandom_range(40, 120));
      glitch_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 35)) : -1;
      glitch_kind = int'($urandom_range(0, 1));
      for (int c = 0; c < n; c++) begin
        rst = (c == glitch_at) && (glitch_kind == 1);
        en  = !((c == glitch_at) && (glitch_kind == 0));
        if (c == n / 2 && $urandom_range(0, 4) == 0) g_mode[$urandom_range(0, NCH - 1)] = 1;
        tick();
      end
      rst = 1'b0;
      en  = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
